// File: rtl/isa_pkg.sv
// Shared ISA definitions for the 16-bit RISC program loader: mnemonic
// classes, opcode/op-field constants, loader states and the imm5 range rule.
package isa_pkg;

  typedef enum logic [3:0] {
    MOV_IMM = 4'd0,
    MOV_REG = 4'd1,
    ADD     = 4'd2,
    CMP     = 4'd3,
    AND     = 4'd4,
    MVN     = 4'd5,
    LDR     = 4'd6,
    STR     = 4'd7,
    HALT    = 4'd8
  } enc_op_e;

  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_STR  = 3'b100;
  localparam logic [2:0] OPC_HALT = 3'b111;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_CMP = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

  localparam logic [1:0] MOV_OP_REG = 2'b00;
  localparam logic [1:0] MOV_OP_IMM = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ld_state_e;

  // An 8-bit immediate is a valid imm5 only if it is the sign extension of its low 5 bits.
  function automatic logic imm5_fits(input logic [7:0] imm);
    return (imm[7:5] == {3{imm[4]}});
  endfunction

endpackage

// File: rtl/iencoder_loader_iencode.sv
// Combinational packer: instruction description -> 16-bit core encoding
// plus a legality flag.
module iencode
  import isa_pkg::*;
(
  input  logic [3:0]  enc_op_i,
  input  logic [2:0]  rn_i,
  input  logic [2:0]  rd_i,
  input  logic [2:0]  rm_i,
  input  logic [1:0]  shift_i,
  input  logic [7:0]  imm_i,
  output logic [15:0] word_o,
  output logic        legal_o
);

  // Field packing per mnemonic class; unknown classes are illegal.
  always_comb begin
    word_o  = 16'h0000;
    legal_o = 1'b0;
    case (enc_op_e'(enc_op_i))
      MOV_IMM: begin
        word_o  = {OPC_MOV, MOV_OP_IMM, rn_i, imm_i};
        legal_o = 1'b1;
      end
      MOV_REG: begin
        word_o  = {OPC_MOV, MOV_OP_REG, 3'b000, rd_i, shift_i, rm_i};
        legal_o = 1'b1;
      end
      ADD: begin
        word_o  = {OPC_ALU, ALU_ADD, rn_i, rd_i, shift_i, rm_i};
        legal_o = 1'b1;
      end
      CMP: begin
        word_o  = {OPC_ALU, ALU_CMP, rn_i, 3'b000, shift_i, rm_i};
        legal_o = 1'b1;
      end
      AND: begin
        word_o  = {OPC_ALU, ALU_AND, rn_i, rd_i, shift_i, rm_i};
        legal_o = 1'b1;
      end
      MVN: begin
        word_o  = {OPC_ALU, ALU_MVN, 3'b000, rd_i, shift_i, rm_i};
        legal_o = 1'b1;
      end
      LDR: begin
        word_o  = {OPC_LDR, 2'b00, rn_i, rd_i, imm_i[4:0]};
        legal_o = imm5_fits(imm_i);
      end
      STR: begin
        word_o  = {OPC_STR, 2'b00, rn_i, rd_i, imm_i[4:0]};
        legal_o = imm5_fits(imm_i);
      end
      HALT: begin
        word_o  = {OPC_HALT, 13'h0000};
        legal_o = 1'b1;
      end
      default: begin
        word_o  = 16'h0000;
        legal_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/iencoder_loader.sv
// Sequential program loader: encodes one description per handshake and writes
// it to instruction RAM at consecutive addresses until HALT or memory full.
module iencoder_loader
  import isa_pkg::*;
#(
  parameter int          ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [3:0]        enc_op_i,
  input  logic [2:0]        rn_i,
  input  logic [2:0]        rd_i,
  input  logic [2:0]        rm_i,
  input  logic [1:0]        shift_i,
  input  logic [7:0]        imm_i,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [15:0]       mem_wdata_o,
  output logic              done_o,
  output logic              full_o,
  output logic              err_o,
  output logic [ADDR_W:0]   count_o
);

  ld_state_e         state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [15:0]       mem_wdata_q;
  logic              mem_write_q;
  logic              in_ready_q;
  logic              done_q;
  logic              full_q;
  logic              err_q;
  logic [15:0]       word_s;
  logic              legal_s;
  logic              is_halt_s;

  iencode u_iencode (
    .enc_op_i (enc_op_i),
    .rn_i     (rn_i),
    .rd_i     (rd_i),
    .rm_i     (rm_i),
    .shift_i  (shift_i),
    .imm_i    (imm_i),
    .word_o   (word_s),
    .legal_o  (legal_s)
  );

  assign is_halt_s = (enc_op_i == HALT);
  assign addr_d    = addr_q + ADDR_W'(1);

  // Session FSM with address/count bookkeeping and the registered write port.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      addr_q      <= {ADDR_W{1'b0}};
      count_q     <= {(ADDR_W+1){1'b0}};
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= 16'h0000;
      mem_write_q <= 1'b0;
      in_ready_q  <= 1'b0;
      done_q      <= 1'b0;
      full_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      mem_write_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            state_q    <= ST_RUN;
            addr_q     <= ADDR_W'(BASE_ADDR);
            count_q    <= {(ADDR_W+1){1'b0}};
            err_q      <= 1'b0;
            full_q     <= 1'b0;
            done_q     <= 1'b0;
            in_ready_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (in_valid_i && in_ready_q) begin
            if (legal_s) begin
              mem_write_q <= 1'b1;
              mem_addr_q  <= addr_q;
              mem_wdata_q <= word_s;
              addr_q      <= addr_d;
              count_q     <= count_q + {{ADDR_W{1'b0}}, 1'b1};
              // HALT on the last address ends the session without flagging full.
              if (is_halt_s) begin
                state_q    <= ST_DONE;
                done_q     <= 1'b1;
                in_ready_q <= 1'b0;
              end else if (&addr_q) begin
                state_q    <= ST_DONE;
                done_q     <= 1'b1;
                full_q     <= 1'b1;
                in_ready_q <= 1'b0;
              end
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          in_ready_q <= 1'b0;
          done_q     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign mem_write_o = mem_write_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign done_o      = done_q;
  assign full_o      = full_q;
  assign err_o       = err_q;
  assign count_o     = count_q;

endmodule

// File: doc/iencoder_loader.md
# iencoder_loader

Sequential program loader for the 16-bit RISC core. It accepts one instruction description per handshake (mnemonic class plus register, shift and immediate fields) and packs it into the 16-bit encoding that the core's instruction decoder consumes. It then writes the word into instruction memory at consecutive addresses and stops after a HALT or when memory is full. It sits between the debug/host front-end and the instruction RAM write port.

## Interface
- ADDR_W, 8: instruction memory address width.
- BASE_ADDR, 0: first address written after `start`.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load session (accepted in IDLE or DONE only).
- in_valid  in  1  instruction description valid.
- in_ready  out  1  loader accepts a description this cycle.
- enc_op  in  4  mnemonic class (isa_pkg::enc_op_e).
- rn, rd, rm  in  3 each  register fields.
- shift  in  2  shift code.
- imm  in  8  immediate; imm8 for MOV-immediate, signed imm5 (must be sign-extended to 8 bits) for LDR/STR.
- mem_write  out  1  instruction RAM write strobe.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  16  encoded instruction.
- done  out  1  session finished (level, held in DONE).
- full  out  1  session ended by address exhaustion, not HALT.
- err  out  1  sticky; at least one description rejected this session.
- count  out  ADDR_W+1  number of words written this session.

## Operation
- Encoding: [15:13] opcode, [12:11] op, [10:8] Rn, [7:5] Rd, [4:3] shift, [2:0] Rm; imm8 = [7:0]; imm5 = [4:0].
- MOV_IMM: 110_10_Rn_imm8.
- MOV_REG: 110_00_000_Rd_sh_Rm.
- ADD/CMP/AND/MVN: 101_op_Rn_Rd_sh_Rm, with op = 00/01/10/11. CMP forces Rd=000. MVN forces Rn=000.
- LDR: 011_00_Rn_Rd_imm5. STR: 100_00_Rn_Rd_imm5.
- HALT: 16'hE000.
- Illegal descriptions:
  - enc_op values 9–15.
  - LDR/STR with imm[7:5] not all equal to imm[4].
- An illegal description is consumed (handshake completes), nothing is written, err is set, and the address does not advance.
- FSM IDLE → RUN on start: addr←BASE_ADDR, count←0, err←0, full←0.
- RUN: in_ready=1. On a legal transfer, the word is registered for writing, addr increments and count increments.
  - A legal HALT is written, then the FSM goes to DONE.
  - A legal write to address 2^ADDR_W−1 goes to DONE with full=1.
  - When HALT lands on the last address, full=0 (HALT takes precedence).
- DONE: done=1, in_ready=0; start re-enters RUN with the same initialisation as from IDLE.
- start while in RUN is ignored.
- Address arithmetic is ADDR_W-bit; no wrap occurs because the last address terminates the session.

## Timing
- Reset values: in_ready=0, mem_write=0, mem_addr=0, mem_wdata=0, done=0, full=0, err=0, count=0, state IDLE.
- Transfer = in_valid && in_ready at a rising edge.
- mem_write is asserted for exactly one cycle, in the cycle after a legal transfer, with mem_addr/mem_wdata valid in that same cycle.
- Throughput is one word per cycle; back-to-back transfers produce back-to-back writes at consecutive addresses.
- in_ready falls in the cycle after the terminating (HALT/full) transfer. That cycle also carries its mem_write, and done rises in the same cycle.
- Reset mid-session: any pending write is dropped (mem_write=0 in the cycle after reset) and all outputs return to reset values.
- count reflects writes issued, updated together with mem_write.

## Structure
- Package isa_pkg:
  - enc_op_e: MOV_IMM=0, MOV_REG=1, ADD=2, CMP=3, AND=4, MVN=5, LDR=6, STR=7, HALT=8.
  - Opcode constants OPC_MOV=3'b110, OPC_ALU=3'b101, OPC_LDR=3'b011, OPC_STR=3'b100, OPC_HALT=3'b111.
  - ALU op constants and the loader state enum.
- Sub-module iencode: purely combinational; maps enc_op and fields to {word[15:0], legal}. The loader holds the FSM, the address/count registers and the write register.

## Test plan
- start, then MOV_IMM rn=0 imm=8'h22 → one cycle later mem_write=1, mem_addr=0, mem_wdata=16'hD022; count=1.
- ADD rn=2 rd=1 shift=2'b11 rm=0, then MOV_REG rd=1 rm=2 back-to-back → writes 16'hA238 at 0 and 16'hC022 at 1 on consecutive cycles.
- LDR rn=2 rd=1 imm=8'hF0 → 16'h6230. STR imm=8'h10 → no write, err=1, next legal word still goes to address 1.
- HALT after 3 words → 16'hE000 at address 3, done=1, full=0, count=4, in_ready=0. in_valid held high afterwards produces no writes.
- ADDR_W=2, four legal non-HALT words → last write at address 3, done=1, full=1. A new start resets count/err and writes from address 0 again.
- rst asserted in the cycle after a transfer → no mem_write occurs, all outputs zero, state IDLE.
